cpu_multicycle_ctrl: RTL and testbench
======================================

# cpu_multicycle_ctrl

Multi-cycle control unit for the MIPS processor. It sequences every instruction through FETCH, DECODE, EXECUTE, MEM and WB states, and drives the datapath control word per state. It waits on instruction-memory and data-memory ready handshakes, and counts retired instructions. It sits between the instruction register and the datapath, replacing the single-cycle combinational decoder when the shared-memory multi-cycle datapath is built.

## Interface
- `OPCODE_W`, default 3: opcode width, ≥3. Values with any bit above bit 2 set are illegal.
- `CNT_W`, default 32: width of the retired-instruction counter.
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  reset, synchronous, active-low
- `opcode`  in  OPCODE_W  instruction opcode; sampled in DECODE only
- `imem_ready`  in  1  instruction memory has data; qualifies FETCH
- `dmem_ready`  in  1  data memory access complete; qualifies MEM
- `halt`  in  1  when high in FETCH, no new fetch is issued
- `imem_rd`, `ir_wr`, `pc_wr`  out  1  fetch request, instruction-register load, PC update
- `dest_reg`, `mem_to_reg`, `alu_opcode`  out  2  encodings identical to the single-cycle control unit
- `cpu_jump`, `cpu_branch`, `cpu_mem_rd`, `cpu_mem_wr`, `cpu_alu_src`, `cpu_reg_wr`, `sign_or_zero`  out  1  datapath controls
- `instr_done`  out  1  one-cycle pulse when an instruction retires
- `instr_count`  out  CNT_W  retired-instruction count
- `trap`  out  1  illegal-opcode trap flag; only driven high when `CPU_CTRL_TRAP_EN` is defined, else tied 0
- `state_o`  out  3  current state encoding, for debug

## Operation
- State register and latched opcode `op_q` (3 bits) are the only control registers. All control outputs are Moore functions of `state` and `op_q`.
- Reset: while `rst_n` is low, outputs are forced combinationally to:
  - all strobes 0, `dest_reg`/`mem_to_reg`/`alu_opcode` = 00, `sign_or_zero` = 1
  - `instr_done` = 0, `trap` = 0, `state_o` = FETCH
- At each reset edge: `state` loads FETCH, `op_q` loads 000, `instr_count` loads 0.
- FETCH:
  - `imem_rd` = !`halt`.
  - If `imem_ready` && !`halt`: `ir_wr` = 1 and `pc_wr` = 1 (PC+4) in that same cycle, then go to DECODE.
  - Otherwise stay in FETCH.
- DECODE: latch `opcode[2:0]` into `op_q`.
  - Illegal opcode with macro defined: go to TRAP.
  - Illegal opcode without macro: latch 000 (add).
  - Otherwise go to EXEC.
- EXEC: drive `alu_opcode`, `cpu_alu_src` and `sign_or_zero` per the opcode table (add 00/0/1, sli 10/1/0, lw/sw/addi 11/1/1, beq 01/0/1, j/jal 00/0/1). Next state depends on `op_q`:
  - add, sli, addi: go to WB.
  - j: `cpu_jump` = 1, `pc_wr` = 1, retire, go to FETCH.
  - beq: `cpu_branch` = 1 (datapath gates `pc_wr` with zero flag), retire, go to FETCH.
  - jal: `cpu_jump` = 1, `pc_wr` = 1, go to WB.
  - lw, sw: go to MEM.
- MEM: `cpu_mem_rd` (lw) or `cpu_mem_wr` (sw) is held until `dmem_ready`.
  - lw: go to WB.
  - sw: retire, go to FETCH.
- WB: `cpu_reg_wr` = 1 for exactly one cycle, then retire and go to FETCH.
  - `dest_reg`: 01 for add, 10 for jal, 00 otherwise.
  - `mem_to_reg`: 01 for lw, 10 for jal, 00 otherwise.
- Retire: `instr_done` = 1 in the retiring cycle. `instr_count` increments on that edge and wraps modulo 2^CNT_W.
- Control outputs not listed for a state are 0, except `sign_or_zero`, which follows `op_q`.

## Timing
- Cycles per instruction, with zero-wait memories:
  - j, beq: 3
  - add, sli, addi, jal, sw: 4
  - lw: 5
- Each wait cycle on `imem_ready`/`dmem_ready` adds exactly one cycle.
- `opcode` must be stable in the DECODE cycle only. It is a don't-care elsewhere.
- `halt` is sampled only in FETCH. Asserting it mid-instruction does not stop that instruction.
- `rst_n` low in any state, including MEM with `dmem_ready` low, aborts the instruction without retiring it; no `cpu_reg_wr` or `cpu_mem_wr` is issued in that cycle.
- Ready inputs asserted outside their state are ignored.

## Configuration
- `CPU_CTRL_TRAP_EN` defined:
  - Illegal opcode goes DECODE → TRAP.
  - In TRAP, `trap` = 1 and all strobes are 0. No retire, no exit except reset.
- `CPU_CTRL_TRAP_EN` undefined:
  - TRAP state does not exist and `trap` is tied 0.
  - Illegal opcode executes as add (4 cycles, `dest_reg` = 01).

## Structure
- Package `cpu_ctrl_pkg` holds:
  - state enum: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5
  - opcode localparams (OP_ADD..OP_ADDI = 0..7)
  - ALU-op, `dest_reg` and `mem_to_reg` encodings
  - packed control-word struct
- Sub-module `cpu_ctrl_decode`: purely combinational (`op_q`, `state`) → control word.
- The top level holds the state register, `op_q`, the counter and the reset forcing.

## Test plan
- Reset held 3 cycles, release, `imem_ready` = 1, `opcode` = 000 → add retires on cycle 4. Check `cpu_reg_wr` = 1 and `dest_reg` = 01 in WB; `instr_count` = 1.
- lw with `dmem_ready` low for 2 MEM cycles → `cpu_mem_rd` high for 3 cycles, WB `mem_to_reg` = 01, total 7 cycles.
- Sequence j, beq, jal, sw → `instr_done` pulses at cycles 3, 6, 10, 14. jal has `dest_reg` = 10 and `mem_to_reg` = 10.
- `opcode` = 4'b1000 with `OPCODE_W` = 4:
  - macro defined → TRAP, `trap` = 1 forever, count frozen
  - macro undefined → add behaviour
- `rst_n` low in MEM of sw while `dmem_ready` = 0 → next cycle `state_o` = FETCH, `cpu_mem_wr` = 0, count unchanged.
- `CNT_W` = 4, 16 retired instructions → `instr_count` wraps to 0. `halt` = 1 in FETCH → `imem_rd` = 0, count frozen.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// +----------------------------------------------------------------------------+
// | cpu_ctrl_pkg                                                               |
// | Shared types and encodings for the multi-cycle MIPS control unit.          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_e;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SLI  = 3'd1;
  localparam logic [2:0] OP_J    = 3'd2;
  localparam logic [2:0] OP_JAL  = 3'd3;
  localparam logic [2:0] OP_LW   = 3'd4;
  localparam logic [2:0] OP_SW   = 3'd5;
  localparam logic [2:0] OP_BEQ  = 3'd6;
  localparam logic [2:0] OP_ADDI = 3'd7;

  localparam logic [1:0] ALU_OP_ADD  = 2'b00;
  localparam logic [1:0] ALU_OP_SUB  = 2'b01;
  localparam logic [1:0] ALU_OP_SLI  = 2'b10;
  localparam logic [1:0] ALU_OP_ADDI = 2'b11;

  localparam logic [1:0] DEST_RT = 2'b00;
  localparam logic [1:0] DEST_RD = 2'b01;
  localparam logic [1:0] DEST_RA = 2'b10;

  localparam logic [1:0] M2R_ALU = 2'b00;
  localparam logic [1:0] M2R_MEM = 2'b01;
  localparam logic [1:0] M2R_PC4 = 2'b10;

  typedef struct packed {
    logic       imem_rd;
    logic       ir_wr;
    logic       pc_wr;
    logic [1:0] dest_reg;
    logic [1:0] mem_to_reg;
    logic [1:0] alu_opcode;
    logic       jump;
    logic       branch;
    logic       mem_rd;
    logic       mem_wr;
    logic       alu_src;
    logic       reg_wr;
    logic       sign_or_zero;
    logic       instr_done;
    logic       trap;
  } ctrl_t;

  // Control word presented while reset is held: everything idle, sign-extend.
  function automatic ctrl_t ctrl_reset();
    ctrl_reset              = '0;
    ctrl_reset.sign_or_zero = 1'b1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cpu_ctrl_decode.sv
// +----------------------------------------------------------------------------+
// | cpu_ctrl_decode                                                            |
// | Combinational control word from state, latched opcode and ready inputs.   |
// | Optional feature macro: CPU_CTRL_TRAP_EN (drives trap in TRAP state).      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module cpu_ctrl_decode
  import cpu_ctrl_pkg::*;
(
  input  state_e     state,
  input  logic [2:0] op_q,
  input  logic       halt,
  input  logic       imem_ready,
  input  logic       dmem_ready,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl              = '0;
    ctrl.sign_or_zero = (op_q != OP_SLI);
    case (state)
      ST_FETCH: begin
        ctrl.imem_rd = !halt;
        if (imem_ready && !halt) begin
          ctrl.ir_wr = 1'b1;
          ctrl.pc_wr = 1'b1;
        end
      end
      ST_EXEC: begin
        case (op_q)
          OP_ADD: begin
            ctrl.alu_opcode = ALU_OP_ADD;
          end
          OP_SLI: begin
            ctrl.alu_opcode = ALU_OP_SLI;
            ctrl.alu_src    = 1'b1;
          end
          OP_LW, OP_SW, OP_ADDI: begin
            ctrl.alu_opcode = ALU_OP_ADDI;
            ctrl.alu_src    = 1'b1;
          end
          OP_BEQ: begin
            ctrl.alu_opcode = ALU_OP_SUB;
            ctrl.branch     = 1'b1;
            ctrl.instr_done = 1'b1;
          end
          OP_J: begin
            ctrl.jump       = 1'b1;
            ctrl.pc_wr      = 1'b1;
            ctrl.instr_done = 1'b1;
          end
          OP_JAL: begin
            ctrl.jump  = 1'b1;
            ctrl.pc_wr = 1'b1;
          end
          default: ;
        endcase
      end
      ST_MEM: begin
        if (op_q == OP_LW) begin
          ctrl.mem_rd = 1'b1;
        end else begin
          ctrl.mem_wr     = 1'b1;
          ctrl.instr_done = dmem_ready;
        end
      end
      ST_WB: begin
        ctrl.reg_wr     = 1'b1;
        ctrl.instr_done = 1'b1;
        case (op_q)
          OP_ADD:  ctrl.dest_reg = DEST_RD;
          OP_JAL:  ctrl.dest_reg = DEST_RA;
          default: ctrl.dest_reg = DEST_RT;
        endcase
        case (op_q)
          OP_LW:   ctrl.mem_to_reg = M2R_MEM;
          OP_JAL:  ctrl.mem_to_reg = M2R_PC4;
          default: ctrl.mem_to_reg = M2R_ALU;
        endcase
      end
`ifdef CPU_CTRL_TRAP_EN
      ST_TRAP: begin
        ctrl.trap = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/cpu_multicycle_ctrl.sv
// +----------------------------------------------------------------------------+
// | cpu_multicycle_ctrl                                                        |
// | Multi-cycle MIPS control FSM: state, latched opcode, retire counter.       |
// | Optional feature macro: CPU_CTRL_TRAP_EN (illegal opcode -> TRAP).         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module cpu_multicycle_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int OPCODE_W = 3,
  parameter int CNT_W    = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                imem_ready,
  input  logic                dmem_ready,
  input  logic                halt,
  output logic                imem_rd,
  output logic                ir_wr,
  output logic                pc_wr,
  output logic [1:0]          dest_reg,
  output logic [1:0]          mem_to_reg,
  output logic [1:0]          alu_opcode,
  output logic                cpu_jump,
  output logic                cpu_branch,
  output logic                cpu_mem_rd,
  output logic                cpu_mem_wr,
  output logic                cpu_alu_src,
  output logic                cpu_reg_wr,
  output logic                sign_or_zero,
  output logic                instr_done,
  output logic [CNT_W-1:0]    instr_count,
  output logic                trap,
  output logic [2:0]          state_o
);

  state_e           r_state;
  state_e           w_next_state;
  logic [2:0]       r_op_q;
  logic [2:0]       w_next_op;
  logic [CNT_W-1:0] r_count;
  logic             w_illegal;
  ctrl_t            w_ctrl;
  ctrl_t            w_out;

  generate
    if (OPCODE_W > 3) begin : g_wide_op
      assign w_illegal = |opcode[OPCODE_W-1:3];
    end else begin : g_narrow_op
      assign w_illegal = 1'b0;
    end
  endgenerate

  cpu_ctrl_decode u_decode (
    .state      (r_state),
    .op_q       (r_op_q),
    .halt       (halt),
    .imem_ready (imem_ready),
    .dmem_ready (dmem_ready),
    .ctrl       (w_ctrl)
  );

  always_comb begin
    w_next_state = r_state;
    w_next_op    = r_op_q;
    case (r_state)
      ST_FETCH: begin
        if (imem_ready && !halt) w_next_state = ST_DECODE;
      end
      ST_DECODE: begin
        // Illegal opcodes collapse to add so the non-trap build still retires them.
        w_next_op    = w_illegal ? OP_ADD : opcode[2:0];
        w_next_state = ST_EXEC;
`ifdef CPU_CTRL_TRAP_EN
        if (w_illegal) w_next_state = ST_TRAP;
`endif
      end
      ST_EXEC: begin
        case (r_op_q)
          OP_J, OP_BEQ:  w_next_state = ST_FETCH;
          OP_LW, OP_SW:  w_next_state = ST_MEM;
          default:       w_next_state = ST_WB;
        endcase
      end
      ST_MEM: begin
        if (dmem_ready) w_next_state = (r_op_q == OP_LW) ? ST_WB : ST_FETCH;
      end
      ST_WB: begin
        w_next_state = ST_FETCH;
      end
`ifdef CPU_CTRL_TRAP_EN
      ST_TRAP: begin
        w_next_state = ST_TRAP;
      end
`endif
      default: begin
        w_next_state = ST_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_FETCH;
      r_op_q  <= OP_ADD;
      r_count <= '0;
    end else begin
      r_state <= w_next_state;
      r_op_q  <= w_next_op;
      if (w_ctrl.instr_done) r_count <= r_count + CNT_W'(1);
    end
  end

  // Reset overrides the decoded word so nothing is issued in an aborted cycle.
  assign w_out = rst_n ? w_ctrl : ctrl_reset();

  assign imem_rd      = w_out.imem_rd;
  assign ir_wr        = w_out.ir_wr;
  assign pc_wr        = w_out.pc_wr;
  assign dest_reg     = w_out.dest_reg;
  assign mem_to_reg   = w_out.mem_to_reg;
  assign alu_opcode   = w_out.alu_opcode;
  assign cpu_jump     = w_out.jump;
  assign cpu_branch   = w_out.branch;
  assign cpu_mem_rd   = w_out.mem_rd;
  assign cpu_mem_wr   = w_out.mem_wr;
  assign cpu_alu_src  = w_out.alu_src;
  assign cpu_reg_wr   = w_out.reg_wr;
  assign sign_or_zero = w_out.sign_or_zero;
  assign instr_done   = w_out.instr_done;
  assign trap         = w_out.trap;
  assign instr_count  = r_count;
  assign state_o      = rst_n ? r_state : ST_FETCH;

endmodule

`default_nettype wire

// File: tb/tb_cpu_multicycle_ctrl.sv
// +----------------------------------------------------------------------------+
// | tb_cpu_multicycle_ctrl                                                     |
// | Directed self-checking bench for cpu_multicycle_ctrl (OPCODE_W=4, CNT_W=4).|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_cpu_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] opcode;
  logic       imem_ready;
  logic       dmem_ready;
  logic       halt;
  logic       imem_rd, ir_wr, pc_wr;
  logic [1:0] dest_reg, mem_to_reg, alu_opcode;
  logic       cpu_jump, cpu_branch, cpu_mem_rd, cpu_mem_wr;
  logic       cpu_alu_src, cpu_reg_wr, sign_or_zero;
  logic       instr_done;
  logic [3:0] instr_count;
  logic       trap;
  logic [2:0] state_o;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [3:0] exp_count = 4'd0;

  always #5 clk = ~clk;

  cpu_multicycle_ctrl #(
    .OPCODE_W (4),
    .CNT_W    (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .opcode       (opcode),
    .imem_ready   (imem_ready),
    .dmem_ready   (dmem_ready),
    .halt         (halt),
    .imem_rd      (imem_rd),
    .ir_wr        (ir_wr),
    .pc_wr        (pc_wr),
    .dest_reg     (dest_reg),
    .mem_to_reg   (mem_to_reg),
    .alu_opcode   (alu_opcode),
    .cpu_jump     (cpu_jump),
    .cpu_branch   (cpu_branch),
    .cpu_mem_rd   (cpu_mem_rd),
    .cpu_mem_wr   (cpu_mem_wr),
    .cpu_alu_src  (cpu_alu_src),
    .cpu_reg_wr   (cpu_reg_wr),
    .sign_or_zero (sign_or_zero),
    .instr_done   (instr_done),
    .instr_count  (instr_count),
    .trap         (trap),
    .state_o      (state_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One instruction from FETCH to retire; inputs change at negedge, sampled #1 later.
  // exec_w = {alu_opcode, alu_src, sign_or_zero} in EXEC; wb_w = {dest_reg, mem_to_reg} in WB.
  task automatic run_instr(input logic [3:0] op, input int iw, input int dw,
                           input int exp_cyc, input logic [3:0] exp_exec,
                           input logic [3:0] exp_wb, input int exp_nreg,
                           input int exp_nmem, input string tag);
    int         done_at = 0;
    int         nreg = 0;
    int         nmem = 0;
    logic [3:0] exec_w = 4'h0;
    logic [3:0] wb_w = 4'h0;
    for (int i = 1; i <= 30 && done_at == 0; i++) begin
      opcode     = op;
      imem_ready = (i > iw);
      dmem_ready = (i >= iw + 4 + dw);
      #1;
      if (cpu_mem_rd || cpu_mem_wr) nmem++;
      if (cpu_reg_wr) begin
        nreg++;
        wb_w = {dest_reg, mem_to_reg};
      end
      if (i == iw + 3) exec_w = {alu_opcode, cpu_alu_src, sign_or_zero};
      if (instr_done) done_at = i;
      @(negedge clk);
    end
    exp_count = exp_count + 4'd1;
    check($sformatf("%s cycles", tag), done_at, exp_cyc);
    check($sformatf("%s exec", tag), exec_w, exp_exec);
    check($sformatf("%s wb", tag), wb_w, exp_wb);
    check($sformatf("%s reg_wr", tag), nreg, exp_nreg);
    check($sformatf("%s mem", tag), nmem, exp_nmem);
    check($sformatf("%s count", tag), instr_count, exp_count);
  endtask

  initial begin
    rst_n      = 1'b0;
    opcode     = 4'h0;
    imem_ready = 1'b1;
    dmem_ready = 1'b1;
    halt       = 1'b0;

    // Reset held for three cycles; outputs forced regardless of inputs.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check("rst state", state_o, 3'd0);
      check("rst imem_rd", imem_rd, 1'b0);
      check("rst ir_wr", ir_wr, 1'b0);
      check("rst soz", sign_or_zero, 1'b1);
      check("rst done", instr_done, 1'b0);
      check("rst trap", trap, 1'b0);
      check("rst count", instr_count, 4'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    run_instr(4'b0000, 0, 0, 4, 4'b0001, 4'b0100, 1, 0, "add");
    run_instr(4'b0100, 0, 2, 7, 4'b1111, 4'b0001, 1, 3, "lw");
    run_instr(4'b0010, 0, 0, 3, 4'b0001, 4'b0000, 0, 0, "j");
    run_instr(4'b0110, 0, 0, 3, 4'b0101, 4'b0000, 0, 0, "beq");
    run_instr(4'b0011, 0, 0, 4, 4'b0001, 4'b1010, 1, 0, "jal");
    run_instr(4'b0101, 0, 0, 4, 4'b1111, 4'b0000, 0, 1, "sw");
    run_instr(4'b0000, 2, 0, 6, 4'b0001, 4'b0100, 1, 0, "add_iwait");
    run_instr(4'b0001, 0, 0, 4, 4'b1010, 4'b0000, 1, 0, "sli");
    run_instr(4'b0111, 0, 0, 4, 4'b1111, 4'b0000, 1, 0, "addi");

    // Halt in FETCH: no fetch request, no progress, counter frozen.
    halt       = 1'b1;
    imem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("halt imem_rd", imem_rd, 1'b0);
      check("halt ir_wr", ir_wr, 1'b0);
      check("halt state", state_o, 3'd0);
      @(negedge clk);
    end
    check("halt count", instr_count, exp_count);
    halt = 1'b0;

    for (int k = 0; k < 7; k++) run_instr(4'b0000, 0, 0, 4, 4'b0001, 4'b0100, 1, 0, "add_fill");
    check("wrap count", instr_count, 4'd0);

    // sw stalled in MEM, then aborted by reset.
    opcode     = 4'b0101;
    imem_ready = 1'b1;
    dmem_ready = 1'b0;
    for (int i = 0; i < 3; i++) @(negedge clk);
    #1;
    check("abort pre state", state_o, 3'd3);
    check("abort pre mem_wr", cpu_mem_wr, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort state", state_o, 3'd0);
    check("abort mem_wr", cpu_mem_wr, 1'b0);
    check("abort done", instr_done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("abort post state", state_o, 3'd0);
    check("abort post count", instr_count, 4'd0);
    exp_count = 4'd0;

    // Illegal opcode (bit 3 set).
`ifdef CPU_CTRL_TRAP_EN
    opcode     = 4'b1000;
    imem_ready = 1'b1;
    dmem_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      #1;
      check("trap state", state_o, 3'd5);
      check("trap flag", trap, 1'b1);
      check("trap done", instr_done, 1'b0);
      check("trap reg_wr", cpu_reg_wr, 1'b0);
      @(negedge clk);
    end
    check("trap count", instr_count, 4'd0);
`else
    run_instr(4'b1000, 0, 0, 4, 4'b0001, 4'b0100, 1, 0, "illegal");
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule

`default_nettype wire
